i2c_multi_slave_responder: RTL
==============================

// Module: i2c_multi_slave_responder
// PURPOSE
//  Synthesisable I2C slave responder: the RTL counterpart of the bench's single-address slave model.
//  Answers up to NUM_ADDR slave addresses. Streams written bytes out and fetches read bytes through a
//  valid/ready handshake, with optional SCL clock stretching. Sits beside the IICMB DUT as an on-chip
//  target on the open-drain SCL/SDA bus.
// PARAMETERS
//  NUM_ADDR     2                  number of address slots answered
//  ADDR_WIDTH   7                  I2C address width (7 only; 10-bit out of scope)
//  DATA_WIDTH   8                  bits per data byte
//  SLAVE_ADDRS  {7'h23,7'h22}      packed NUM_ADDR*ADDR_WIDTH; slot k = bits [k*ADDR_WIDTH +: ADDR_WIDTH]
//  SYNC_STAGES  2                  input synchroniser depth for scl_i/sda_i (min 2)
//  STRETCH_EN   1                  1 = hold SCL low while read data is pending; 0 = never stretch
// PORTS
//  clk_i        in   1                        system clock; must be >= 8x SCL frequency
//  rst_i        in   1                        synchronous, active-high reset
//  scl_i        in   1                        SCL pin level
//  sda_i        in   1                        SDA pin level
//  scl_pull_o   out  1                        1 = drive SCL low (stretch); 0 = release
//  sda_pull_o   out  1                        1 = drive SDA low; 0 = release
//  start_o      out  1                        pulse: START or repeated START detected
//  stop_o       out  1                        pulse: STOP detected
//  busy_o       out  1                        high from START to STOP
//  slot_o       out  $clog2(NUM_ADDR)         matched slot; valid while op_valid_o
//  op_o         out  1                        0 = write, 1 = read; valid while op_valid_o
//  op_valid_o   out  1                        high from address ACK until the next START/STOP
//  wr_valid_o   out  1                        pulse: wr_data_o holds a received byte
//  wr_data_o    out  DATA_WIDTH               received write byte
//  rd_ready_o   out  1                        slave is waiting for the next read byte
//  rd_valid_i   in   1                        rd_data_i is valid; accepted when rd_valid_i & rd_ready_o
//  rd_data_i    in   DATA_WIDTH               read byte to return to the master
//  rd_nack_o    out  1                        pulse: master NACKed a read byte (end of read)
//  rd_underrun_o out 1                        pulse: STRETCH_EN=0 and no data at the fetch point; 0xFF sent
// BEHAVIOUR
//  Reset: every output 0, including both pull outputs, so the bus is released. FSM -> IDLE. Reset
//   mid-transfer releases SCL/SDA on the next clock; bus traffic is ignored until the next START.
//  Inputs pass through SYNC_STAGES flops, then a 1-flop edge detector. Events are flagged
//   SYNC_STAGES+1 clocks after the pin changes.
//  START = SDA falls while SCL high; STOP = SDA rises while SCL high. Both take effect from any state.
//   START -> ADDR. STOP -> IDLE. Either one clears op_valid_o; START also sets busy_o, STOP clears it.
//  Bits are sampled on the SCL rising edge. sda_pull_o changes only on the clock after an SCL falling edge.
//  FSM: IDLE, ADDR, ADDR_ACK, IGNORE, WR_DATA, WR_ACK, RD_FETCH, RD_DATA, RD_ACK.
//  ADDR: shift in ADDR_WIDTH address bits MSB first, then the R/W bit. On a match (lowest slot wins
//   on duplicates) -> ADDR_ACK. With no match -> IGNORE: SDA is never driven and the block waits
//   for START/STOP.
//  ADDR_ACK / WR_ACK: drive SDA low from the SCL fall after the last bit to the next SCL fall.
//   After ADDR_ACK: write -> WR_DATA, read -> RD_FETCH.
//  WR_DATA: after DATA_WIDTH bits, wr_valid_o pulses for 1 clock on the 8th-bit rise (no backpressure).
//   Then -> WR_ACK -> WR_DATA.
//  RD_FETCH: rd_ready_o=1. If STRETCH_EN=1, scl_pull_o is asserted on the first clock SCL is seen low
//   and held until the handshake completes. The byte is loaded on the handshake, SCL is released the
//   next clock, then -> RD_DATA. If STRETCH_EN=0 and no valid byte by the SCL fall, the block loads 0xFF
//   and pulses rd_underrun_o.
//  RD_DATA: shift out MSB first; sda_pull_o = ~bit, updated after each SCL fall. SDA is released after
//   the last bit.
//  RD_ACK: sample SDA on the SCL rise. ACK(0) -> RD_FETCH. NACK(1) -> pulse rd_nack_o -> IGNORE.
//  Handshake and START/STOP in the same clock: START/STOP wins and the byte is not consumed.
//  Bit counter is $clog2(DATA_WIDTH+1) bits and clears on every START and on each state entry.
// TESTING
//  1 Write 0x22, bytes A5,3C,FF then STOP -> ACK on all 4; wr_valid_o x3 with A5,3C,FF; slot_o=0, op_o=0.
//  2 Read 0x23, 2 bytes, rd_valid_i delayed 50 clks -> SCL held low ~50 clks; master gets 5A,C3; ACK then NACK -> rd_nack_o=1.
//  3 Address 0x30 write -> SDA never driven (NACK); no wr_valid_o; op_valid_o stays 0; busy_o 1 until STOP.
//  4 Write 0x22 byte 11, repeated START, read 0x22 -> start_o x2; op_o 0 -> 1; byte 11 streamed; one rd_ready_o handshake.
//  5 STRETCH_EN=0, read with rd_valid_i=0 -> master reads FF; rd_underrun_o pulses; scl_pull_o stays 0.
//  6 rst_i during RD_DATA while SDA driven low -> sda_pull_o=scl_pull_o=0 next clk; next START handled normally.

Source files
------------

// File: rtl/i2c_multi_slave_responder_if.sv
// Pin, event and byte-stream signals of the I2C target responder.
// The slave modport is the responder side; master is the environment driving pins and read data.
interface i2c_multi_slave_responder_if #(
  parameter int NUM_ADDR   = 2,
  parameter int DATA_WIDTH = 8
);
  localparam int SLOT_W = (NUM_ADDR > 1) ? $clog2(NUM_ADDR) : 1;

  logic                  scl_i;
  logic                  sda_i;
  logic                  scl_pull_o;
  logic                  sda_pull_o;
  logic                  start_o;
  logic                  stop_o;
  logic                  busy_o;
  logic [SLOT_W-1:0]     slot_o;
  logic                  op_o;
  logic                  op_valid_o;
  logic                  wr_valid_o;
  logic [DATA_WIDTH-1:0] wr_data_o;
  logic                  rd_ready_o;
  logic                  rd_valid_i;
  logic [DATA_WIDTH-1:0] rd_data_i;
  logic                  rd_nack_o;
  logic                  rd_underrun_o;

  modport slave (
    input  scl_i, sda_i, rd_valid_i, rd_data_i,
    output scl_pull_o, sda_pull_o, start_o, stop_o, busy_o, slot_o, op_o, op_valid_o,
           wr_valid_o, wr_data_o, rd_ready_o, rd_nack_o, rd_underrun_o
  );

  modport master (
    output scl_i, sda_i, rd_valid_i, rd_data_i,
    input  scl_pull_o, sda_pull_o, start_o, stop_o, busy_o, slot_o, op_o, op_valid_o,
           wr_valid_o, wr_data_o, rd_ready_o, rd_nack_o, rd_underrun_o
  );
endinterface

// File: rtl/i2c_multi_slave_responder.sv
// I2C target for NUM_ADDR addresses: bus events act SYNC_STAGES+1 clks after the pins; write bytes
// stream out without backpressure, read bytes are fetched by valid/ready while SCL is optionally stretched.
module i2c_multi_slave_responder #(
  parameter int                             NUM_ADDR    = 2,
  parameter int                             ADDR_WIDTH  = 7,
  parameter int                             DATA_WIDTH  = 8,
  parameter logic [NUM_ADDR*ADDR_WIDTH-1:0] SLAVE_ADDRS = {7'h23, 7'h22},
  parameter int                             SYNC_STAGES = 2,
  parameter bit                             STRETCH_EN  = 1'b1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  i2c_multi_slave_responder_if.slave bus
);
  localparam int SLOT_W = (NUM_ADDR > 1) ? $clog2(NUM_ADDR) : 1;
  localparam int CW     = $clog2(DATA_WIDTH + 1);
  localparam int SW     = (DATA_WIDTH - 1 > ADDR_WIDTH) ? DATA_WIDTH - 1 : ADDR_WIDTH;

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, IGNORE, WR_DATA, WR_ACK, RD_FETCH, RD_DATA, RD_ACK
  } state_t;

  state_t                state, state_n;
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                  scl_d, sda_d, scl_s, sda_s;
  logic                  scl_rise, scl_fall, start_det, stop_det;
  logic [CW-1:0]         cnt, cnt_n;
  logic [SW-1:0]         shreg, shreg_n;
  logic [DATA_WIDTH-2:0] tx, tx_n;
  logic                  sda_pull, sda_pull_n, scl_pull, scl_pull_n;
  logic                  busy, busy_n, op, op_n, op_valid, op_valid_n;
  logic [SLOT_W-1:0]     slot, slot_n, hit_slot;
  logic                  hit;
  logic [DATA_WIDTH-1:0] wr_data, wr_data_n;
  logic                  start_p, start_p_n, stop_p, stop_p_n, wr_valid, wr_valid_n;
  logic                  rd_nack, rd_nack_n, underrun, underrun_n;
  logic                  rd_ready, hs;

  // Synchronisers idle high so reset never fabricates a START/STOP edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.sda_i};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

  // A bus START/STOP in the same clock withdraws ready so the byte stays with the producer.
  assign rd_ready = (state == RD_FETCH) & ~start_det & ~stop_det;
  assign hs       = rd_ready & bus.rd_valid_i;

  // Descending scan so the lowest matching slot wins.
  always_comb begin
    hit      = 1'b0;
    hit_slot = '0;
    for (int k = NUM_ADDR - 1; k >= 0; k--) begin
      if (shreg[ADDR_WIDTH-1:0] == SLAVE_ADDRS[k*ADDR_WIDTH +: ADDR_WIDTH]) begin
        hit      = 1'b1;
        hit_slot = SLOT_W'(k);
      end
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    shreg_n    = shreg;
    tx_n       = tx;
    sda_pull_n = sda_pull;
    scl_pull_n = scl_pull;
    busy_n     = busy;
    op_n       = op;
    op_valid_n = op_valid;
    slot_n     = slot;
    wr_data_n  = wr_data;
    start_p_n  = 1'b0;
    stop_p_n   = 1'b0;
    wr_valid_n = 1'b0;
    rd_nack_n  = 1'b0;
    underrun_n = 1'b0;
    if (start_det || stop_det) begin
      state_n    = start_det ? ADDR : IDLE;
      cnt_n      = '0;
      busy_n     = start_det;
      op_valid_n = 1'b0;
      sda_pull_n = 1'b0;
      scl_pull_n = 1'b0;
      start_p_n  = start_det;
      stop_p_n   = stop_det;
    end else begin
      case (state)
        ADDR: if (scl_rise) begin
          shreg_n = {shreg[SW-2:0], sda_s};
          cnt_n   = cnt + 1'b1;
          if (cnt == CW'(ADDR_WIDTH)) begin
            cnt_n = '0;
            if (hit) begin
              state_n    = ADDR_ACK;
              op_n       = sda_s;
              slot_n     = hit_slot;
              op_valid_n = 1'b1;
            end else begin
              state_n = IGNORE;
            end
          end
        end
        ADDR_ACK, WR_ACK: if (scl_fall) begin
          if (cnt == '0) begin
            sda_pull_n = 1'b1;
            cnt_n      = CW'(1);
          end else begin
            sda_pull_n = 1'b0;
            cnt_n      = '0;
            state_n    = (state == WR_ACK || !op) ? WR_DATA : RD_FETCH;
          end
        end
        WR_DATA: if (scl_rise) begin
          shreg_n = {shreg[SW-2:0], sda_s};
          cnt_n   = cnt + 1'b1;
          if (cnt == CW'(DATA_WIDTH - 1)) begin
            wr_valid_n = 1'b1;
            wr_data_n  = {shreg[DATA_WIDTH-2:0], sda_s};
            cnt_n      = '0;
            state_n    = WR_ACK;
          end
        end
        RD_FETCH: begin
          if (hs) begin
            tx_n       = bus.rd_data_i[DATA_WIDTH-2:0];
            sda_pull_n = ~bus.rd_data_i[DATA_WIDTH-1];
            cnt_n      = '0;
            state_n    = RD_DATA;
          end else if (STRETCH_EN) begin
            if (!scl_s) scl_pull_n = 1'b1;
          end else begin
            // Without stretching the MSB must be on SDA now; an all-ones byte leaves SDA released.
            tx_n       = '1;
            sda_pull_n = 1'b0;
            underrun_n = 1'b1;
            cnt_n      = '0;
            state_n    = RD_DATA;
          end
        end
        RD_DATA: begin
          scl_pull_n = 1'b0;
          if (scl_rise) cnt_n = cnt + 1'b1;
          if (scl_fall) begin
            if (cnt == CW'(DATA_WIDTH)) begin
              sda_pull_n = 1'b0;
              cnt_n      = '0;
              state_n    = RD_ACK;
            end else begin
              sda_pull_n = ~tx[DATA_WIDTH-2];
              tx_n       = {tx[DATA_WIDTH-3:0], 1'b0};
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            if (sda_s) begin
              rd_nack_n = 1'b1;
              state_n   = IGNORE;
            end else begin
              cnt_n = CW'(1);
            end
          end else if (scl_fall && cnt == CW'(1)) begin
            cnt_n   = '0;
            state_n = RD_FETCH;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      cnt      <= '0;
      shreg    <= '0;
      tx       <= '0;
      sda_pull <= 1'b0;
      scl_pull <= 1'b0;
      busy     <= 1'b0;
      op       <= 1'b0;
      op_valid <= 1'b0;
      slot     <= '0;
      wr_data  <= '0;
      start_p  <= 1'b0;
      stop_p   <= 1'b0;
      wr_valid <= 1'b0;
      rd_nack  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      shreg    <= shreg_n;
      tx       <= tx_n;
      sda_pull <= sda_pull_n;
      scl_pull <= scl_pull_n;
      busy     <= busy_n;
      op       <= op_n;
      op_valid <= op_valid_n;
      slot     <= slot_n;
      wr_data  <= wr_data_n;
      start_p  <= start_p_n;
      stop_p   <= stop_p_n;
      wr_valid <= wr_valid_n;
      rd_nack  <= rd_nack_n;
      underrun <= underrun_n;
    end
  end

  assign bus.scl_pull_o    = scl_pull;
  assign bus.sda_pull_o    = sda_pull;
  assign bus.start_o       = start_p;
  assign bus.stop_o        = stop_p;
  assign bus.busy_o        = busy;
  assign bus.slot_o        = slot;
  assign bus.op_o          = op;
  assign bus.op_valid_o    = op_valid;
  assign bus.wr_valid_o    = wr_valid;
  assign bus.wr_data_o     = wr_data;
  assign bus.rd_ready_o    = rd_ready;
  assign bus.rd_nack_o     = rd_nack;
  assign bus.rd_underrun_o = underrun;
endmodule
